// File: rtl/por_rst_seq.sv
// rtl/por_rst_seq.sv - reset-release sequencer following the POR pulse
module por_rst_seq #(
  parameter int          NDOM      = 4,
  parameter int          GAPW      = 8,
  parameter int          ACK_TO    = 255,
  parameter logic [2:0]  OTRIP_RST = 3'b000
) (
  input  logic             osc_ck,
  input  logic             rsb,
  input  logic             por_in,
  input  logic             startup_done,
  input  logic [GAPW-1:0]  gap,
  input  logic             ack_en,
  input  logic [NDOM-1:0]  dom_ack,
  input  logic             otrip_wr,
  input  logic [2:0]       otrip_req,
  output logic [NDOM-1:0]  dom_rstb,
  output logic [2:0]       otrip,
  output logic             otrip_ack,
  output logic             otrip_rej,
  output logic             seq_done,
  output logic             seq_err,
  output logic [2:0]       state
);

  localparam int             IW      = (NDOM > 1) ? $clog2(NDOM) : 1;
  localparam logic [IW-1:0]  IDX_LAST = IW'(NDOM - 1);
  // to_cnt holds cycles already spent in WAIT_ACK; timeout fires on the edge it would reach ACK_TO
  localparam logic [9:0]     TO_LAST  = 10'(ACK_TO - 1);

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    ARMED    = 3'd1,
    RELEASE  = 3'd2,
    GAP      = 3'd3,
    WAIT_ACK = 3'd4,
    DONE     = 3'd5,
    ERR      = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [GAPW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [9:0]        to_cnt_q, to_cnt_d;
  logic [GAPW-1:0]   gap_lat_q, gap_lat_d;
  logic              ack_en_lat_q, ack_en_lat_d;
  logic [NDOM-1:0]   dom_rstb_q, dom_rstb_d;
  logic [2:0]        otrip_q, otrip_d;
  logic              otrip_ack_q, otrip_ack_d;
  logic              otrip_rej_q, otrip_rej_d;
  logic              seq_done_q, seq_done_d;
  logic              seq_err_q, seq_err_d;
  logic              retrig;
  logic              advance;

  // next-state and next-output computation; outputs are registered from these
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_cnt_d    = gap_cnt_q;
    to_cnt_d     = to_cnt_q;
    gap_lat_d    = gap_lat_q;
    ack_en_lat_d = ack_en_lat_q;
    dom_rstb_d   = dom_rstb_q;
    otrip_d      = otrip_q;
    otrip_ack_d  = 1'b0;
    otrip_rej_d  = 1'b0;
    seq_done_d   = seq_done_q;
    seq_err_d    = seq_err_q;
    advance      = 1'b0;
    retrig       = por_in && (state_q inside {RELEASE, GAP, WAIT_ACK, DONE, ERR});

    if (retrig) begin
      // a new POR pulse outranks any trip write; the write is refused
      state_d      = ARMED;
      idx_d        = '0;
      dom_rstb_d   = '0;
      seq_done_d   = 1'b0;
      seq_err_d    = 1'b0;
      gap_lat_d    = gap;
      ack_en_lat_d = ack_en;
      otrip_rej_d  = otrip_wr;
    end else begin
      if (otrip_wr) begin
        if (state_q == DONE) begin
          otrip_d     = otrip_req;
          otrip_ack_d = 1'b1;
        end else begin
          otrip_rej_d = 1'b1;
        end
      end

      case (state_q)
        HOLD: begin
          if (por_in && startup_done) begin
            state_d      = ARMED;
            gap_lat_d    = gap;
            ack_en_lat_d = ack_en;
          end
        end
        ARMED: begin
          if (!por_in) state_d = RELEASE;
        end
        RELEASE: begin
          dom_rstb_d[idx_q] = 1'b1;
          if (ack_en_lat_q) begin
            state_d  = WAIT_ACK;
            to_cnt_d = '0;
          end else begin
            advance = 1'b1;
          end
        end
        GAP: begin
          gap_cnt_d = gap_cnt_q - GAPW'(1);
          if (gap_cnt_q <= GAPW'(1)) begin
            idx_d   = idx_q + IW'(1);
            state_d = RELEASE;
          end
        end
        WAIT_ACK: begin
          // ack is checked first so a coincident timeout loses
          if (dom_ack[idx_q]) begin
            advance = 1'b1;
          end else if (to_cnt_q >= TO_LAST) begin
            state_d   = ERR;
            seq_err_d = 1'b1;
          end else if (to_cnt_q != 10'h3ff) begin
            to_cnt_d = to_cnt_q + 10'd1;
          end
        end
        DONE: ;
        ERR: ;
        default: state_d = HOLD;
      endcase

      // shared hand-off after a domain is released (and acknowledged if required)
      if (advance) begin
        if (idx_q == IDX_LAST) begin
          state_d    = DONE;
          seq_done_d = 1'b1;
        end else if (gap_lat_q == '0) begin
          idx_d   = idx_q + IW'(1);
          state_d = RELEASE;
        end else begin
          gap_cnt_d = gap_lat_q;
          state_d   = GAP;
        end
      end
    end
  end

  // state and output registers with synchronous active-low reset
  always_ff @(posedge osc_ck) begin
    if (!rsb) begin
      state_q      <= HOLD;
      idx_q        <= '0;
      gap_cnt_q    <= '0;
      to_cnt_q     <= '0;
      gap_lat_q    <= '0;
      ack_en_lat_q <= 1'b0;
      dom_rstb_q   <= '0;
      otrip_q      <= OTRIP_RST;
      otrip_ack_q  <= 1'b0;
      otrip_rej_q  <= 1'b0;
      seq_done_q   <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_cnt_q    <= gap_cnt_d;
      to_cnt_q     <= to_cnt_d;
      gap_lat_q    <= gap_lat_d;
      ack_en_lat_q <= ack_en_lat_d;
      dom_rstb_q   <= dom_rstb_d;
      otrip_q      <= otrip_d;
      otrip_ack_q  <= otrip_ack_d;
      otrip_rej_q  <= otrip_rej_d;
      seq_done_q   <= seq_done_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign dom_rstb  = dom_rstb_q;
  assign otrip     = otrip_q;
  assign otrip_ack = otrip_ack_q;
  assign otrip_rej = otrip_rej_q;
  assign seq_done  = seq_done_q;
  assign seq_err   = seq_err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_por_rst_seq.sv
// tb/tb_por_rst_seq.sv - directed self-checking bench for por_rst_seq
module tb_por_rst_seq;

  localparam int NDOM = 4;

  logic            osc_ck = 1'b0;
  logic            rsb = 1'b0;
  logic            por_in = 1'b0;
  logic            startup_done = 1'b0;
  logic [7:0]      gap = 8'd0;
  logic            ack_en = 1'b0;
  logic [NDOM-1:0] dom_ack = '0;
  logic            otrip_wr = 1'b0;
  logic [2:0]      otrip_req = 3'b000;
  logic [NDOM-1:0] dom_rstb;
  logic [2:0]      otrip;
  logic            otrip_ack;
  logic            otrip_rej;
  logic            seq_done;
  logic            seq_err;
  logic [2:0]      state;

  int n_vec = 0;
  int n_err = 0;

  por_rst_seq #(.NDOM(NDOM), .GAPW(8), .ACK_TO(16), .OTRIP_RST(3'b000)) dut (
    .osc_ck(osc_ck), .rsb(rsb), .por_in(por_in), .startup_done(startup_done),
    .gap(gap), .ack_en(ack_en), .dom_ack(dom_ack), .otrip_wr(otrip_wr),
    .otrip_req(otrip_req), .dom_rstb(dom_rstb), .otrip(otrip),
    .otrip_ack(otrip_ack), .otrip_rej(otrip_rej), .seq_done(seq_done),
    .seq_err(seq_err), .state(state)
  );

  always #5 osc_ck = ~osc_ck;

  task automatic tick();
    @(posedge osc_ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    tick(); tick();
    chk("rst_dom", 32'(dom_rstb), 32'h0);
    chk("rst_otrip", 32'(otrip), 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_done", 32'(seq_done), 32'h0);
    chk("rst_err", 32'(seq_err), 32'h0);
    chk("rst_ack_rej", {30'd0, otrip_ack, otrip_rej}, 32'h0);

    // POR without startup_done stays in HOLD
    rsb = 1'b1; por_in = 1'b1; gap = 8'd3; ack_en = 1'b0;
    tick();
    chk("hold_no_startup", 32'(state), 32'd0);
    startup_done = 1'b1;
    repeat (5) tick();
    chk("armed", 32'(state), 32'd1);
    chk("armed_dom", 32'(dom_rstb), 32'h0);

    // gap=3, no ack: releases at E0+1, +5, +9, +13
    por_in = 1'b0;
    tick();
    chk("e0_release", 32'(state), 32'd2);
    tick();
    chk("d0_rel", 32'(dom_rstb), 32'b0001);
    chk("d0_gap", 32'(state), 32'd3);
    otrip_wr = 1'b1; otrip_req = 3'b101;
    tick();
    otrip_wr = 1'b0;
    chk("rej_pulse", 32'(otrip_rej), 32'h1);
    chk("rej_otrip", 32'(otrip), 32'h0);
    chk("rej_noack", 32'(otrip_ack), 32'h0);
    tick();
    chk("rej_one_cycle", 32'(otrip_rej), 32'h0);
    tick();
    chk("e0p4_dom", 32'(dom_rstb), 32'b0001);
    tick();
    chk("e0p5_dom", 32'(dom_rstb), 32'b0011);
    repeat (3) tick();
    chk("e0p8_dom", 32'(dom_rstb), 32'b0011);
    tick();
    chk("e0p9_dom", 32'(dom_rstb), 32'b0111);
    repeat (3) tick();
    chk("e0p12_done", 32'(seq_done), 32'h0);
    tick();
    chk("e0p13_dom", 32'(dom_rstb), 32'b1111);
    chk("e0p13_done", 32'(seq_done), 32'h1);
    chk("e0p13_state", 32'(state), 32'd5);

    // trip write in DONE accepted
    otrip_wr = 1'b1; otrip_req = 3'b101;
    tick();
    otrip_wr = 1'b0;
    chk("acc_otrip", 32'(otrip), 32'b101);
    chk("acc_pulse", 32'(otrip_ack), 32'h1);
    tick();
    chk("acc_one_cycle", 32'(otrip_ack), 32'h0);

    // retrigger from DONE, then retrigger in GAP after domain 1
    por_in = 1'b1;
    tick();
    chk("retrig_dom", 32'(dom_rstb), 32'h0);
    chk("retrig_done", 32'(seq_done), 32'h0);
    chk("retrig_otrip", 32'(otrip), 32'b101);
    tick();
    por_in = 1'b0;
    tick();
    tick();
    chk("r2_d0", 32'(dom_rstb), 32'b0001);
    repeat (4) tick();
    chk("r2_d1", 32'(dom_rstb), 32'b0011);
    tick();
    chk("r2_gap", 32'(state), 32'd3);
    por_in = 1'b1;
    tick();
    por_in = 1'b0;
    chk("gap_retrig_dom", 32'(dom_rstb), 32'h0);
    chk("gap_retrig_state", 32'(state), 32'd1);
    tick();
    tick();
    chk("restart_d0", 32'(dom_rstb), 32'b0001);

    // gap=0 with ack two cycles after each release
    gap = 8'd0; ack_en = 1'b1; por_in = 1'b1;
    tick();
    por_in = 1'b0;
    tick();
    for (int k = 0; k < NDOM; k++) begin
      tick();
      chk("ack_rel_dom", 32'(dom_rstb), (32'h1 << (k + 1)) - 32'h1);
      chk("ack_wait_state", 32'(state), 32'd4);
      tick();
      dom_ack = NDOM'(1 << k);
      tick();
      dom_ack = '0;
    end
    chk("ack_done", 32'(seq_done), 32'h1);
    chk("ack_noerr", 32'(seq_err), 32'h0);
    chk("ack_state", 32'(state), 32'd5);

    // timeout with no ack: ERR at R+16
    por_in = 1'b1;
    tick();
    por_in = 1'b0;
    tick();
    tick();
    chk("to_rel", 32'(dom_rstb), 32'b0001);
    repeat (15) tick();
    chk("to_r15_state", 32'(state), 32'd4);
    tick();
    chk("to_err_state", 32'(state), 32'd6);
    chk("to_err", 32'(seq_err), 32'h1);
    chk("to_err_dom", 32'(dom_rstb), 32'b0001);
    por_in = 1'b1;
    tick();
    por_in = 1'b0;
    chk("err_retrig_dom", 32'(dom_rstb), 32'h0);
    chk("err_retrig_err", 32'(seq_err), 32'h0);
    chk("err_retrig_state", 32'(state), 32'd1);

    // ack coincident with timeout edge: ack wins
    tick();
    tick();
    repeat (15) tick();
    dom_ack = 4'b0001;
    tick();
    dom_ack = '0;
    chk("coinc_state", 32'(state), 32'd2);
    chk("coinc_err", 32'(seq_err), 32'h0);
    tick();
    chk("coinc_d1", 32'(dom_rstb), 32'b0011);
    chk("coinc_wait", 32'(state), 32'd4);

    // reset mid-sequence
    rsb = 1'b0;
    tick();
    chk("mid_rst_dom", 32'(dom_rstb), 32'h0);
    chk("mid_rst_otrip", 32'(otrip), 32'h0);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_flags", {28'd0, seq_done, seq_err, otrip_ack, otrip_rej}, 32'h0);
    rsb = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
